// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field offsets, packet packing and injector FSM states.
package noc_pkg;

    // Widest packet any mesh configuration is expected to use.
    localparam int unsigned PKT_MAX_W = 128;

    typedef logic [PKT_MAX_W-1:0] pkt_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Field offsets, LSB first: dst Y, dst X, src Y, src X, payload.
    localparam int unsigned DST_Y_LSB = 0;

    function automatic int unsigned dst_x_lsb(input int unsigned ys);
        return ys;
    endfunction

    function automatic int unsigned src_y_lsb(input int unsigned xs, input int unsigned ys);
        return xs + ys;
    endfunction

    function automatic int unsigned src_x_lsb(input int unsigned xs, input int unsigned ys);
        return xs + 2 * ys;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned xs, input int unsigned ys);
        return 2 * xs + 2 * ys;
    endfunction

    // Assemble a packet; callers truncate the result to their own packet width.
    function automatic pkt_word_t pack_pkt(
        input int unsigned xs,
        input int unsigned ys,
        input pkt_word_t   dst_x,
        input pkt_word_t   dst_y,
        input pkt_word_t   src_x,
        input pkt_word_t   src_y,
        input pkt_word_t   data
    );
        pkt_word_t mask_x;
        pkt_word_t mask_y;
        mask_x = (pkt_word_t'(1) << xs) - pkt_word_t'(1);
        mask_y = (pkt_word_t'(1) << ys) - pkt_word_t'(1);
        return ((dst_y & mask_y) << DST_Y_LSB)
             | ((dst_x & mask_x) << dst_x_lsb(ys))
             | ((src_y & mask_y) << src_y_lsb(xs, ys))
             | ((src_x & mask_x) << src_x_lsb(xs, ys))
             | (data << data_lsb(xs, ys));
    endfunction

endpackage

// File: rtl/pe_injector_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a look-ahead port.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] rdata_next,
    output logic             full,
    output logic             empty,
    output logic             multi
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             wr_en;
    logic             rd_en;

    // A write while full is dropped even when a pop happens in the same cycle.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    assign rdata      = mem[rd_ptr];
    assign rdata_next = mem[rd_ptr + AW'(1)];

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            multi   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_d;
            full    <= (count_d == CW'(DEPTH));
            empty   <= (count_d == CW'(0));
            multi   <= (count_d >= CW'(2));
        end
    end

endmodule

// File: rtl/pe_injector.sv
// PE-side injector: buffers neuron results and fans each out as unicast packets to one column.
module pe_injector
    import noc_pkg::*;
#(
    parameter int unsigned x_coord     = 0,
    parameter int unsigned y_coord     = 0,
    parameter int unsigned x_size      = 2,
    parameter int unsigned y_size      = 2,
    parameter int unsigned data_width  = 8,
    parameter int unsigned total_width = 2 * x_size + 2 * y_size + data_width,
    parameter int unsigned DEST_X      = 1,
    parameter int unsigned DEST_Y0     = 0,
    parameter int unsigned DEST_COUNT  = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_valid,
    input  logic [data_width-1:0]  i_data,
    output logic                   o_ready,
    output logic                   o_sw_valid,
    output logic [total_width-1:0] o_sw_data,
    input  logic                   i_sw_ready,
    output logic                   o_busy,
    output logic [15:0]            o_stall_cnt
);

    localparam int unsigned IW = $clog2(DEST_COUNT) + 1;

    state_t                 state_q;
    state_t                 state_d;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_d;
    logic [total_width-1:0] data_q;
    logic [total_width-1:0] data_d;
    logic                   valid_q;
    logic                   busy_q;
    logic [15:0]            stall_q;

    logic                   push;
    logic                   pop;
    logic [data_width-1:0]  head;
    logic [data_width-1:0]  second;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_multi;
    logic                   fifo_nonempty_d;

    // Build one outgoing packet for a payload and destination row.
    function automatic logic [total_width-1:0] make_pkt(
        input logic [data_width-1:0] d,
        input int unsigned           dy
    );
        return total_width'(pack_pkt(x_size, y_size,
                                     pkt_word_t'(DEST_X), pkt_word_t'(dy),
                                     pkt_word_t'(x_coord), pkt_word_t'(y_coord),
                                     pkt_word_t'(d)));
    endfunction

    assign push = i_valid & ~fifo_full;

    sync_fifo #(
        .WIDTH (data_width),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .wdata      (i_data),
        .pop        (pop),
        .rdata      (head),
        .rdata_next (second),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .multi      (fifo_multi)
    );

    // Next-state, fan-out index and output packet selection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    data_d  = make_pkt(head, DEST_Y0);
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_sw_ready) begin
                    if ((32'(idx_q) + 32'd1) < DEST_COUNT) begin
                        idx_d  = idx_q + IW'(1);
                        data_d = make_pkt(head, DEST_Y0 + 32'(idx_q) + 32'd1);
                    end else begin
                        // Last packet of this word: release its slot and chain the next word.
                        pop = 1'b1;
                        if (fifo_multi) begin
                            data_d = make_pkt(second, DEST_Y0);
                            idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO will hold at least one word after this edge.
    assign fifo_nonempty_d = push | fifo_multi | (~fifo_empty & ~pop);

    // State, output packet, status and stall counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= (state_d == SEND);
            busy_q  <= fifo_nonempty_d | (state_d == SEND);
            if (valid_q && !i_sw_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign o_ready     = ~fifo_full;
    assign o_sw_valid  = valid_q;
    assign o_sw_data   = data_q;
    assign o_busy      = busy_q;
    assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_pe_injector.sv
// Scoreboard bench for pe_injector: directed scenarios plus randomized traffic.
module tb_pe_injector;

    localparam int DC    = 2;
    localparam int SX    = 0;
    localparam int SY    = 0;
    localparam int DX    = 1;
    localparam int DY0   = 0;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_ready;
    logic        o_sw_valid;
    logic [15:0] o_sw_data;
    logic        i_sw_ready;
    logic        o_busy;
    logic [15:0] o_stall_cnt;

    logic        v4;
    logic [7:0]  d4;
    logic        r4;
    logic        o_ready4;
    logic        o_valid4;
    logic [15:0] o_data4;
    logic        o_busy4;
    logic [15:0] o_stall4;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int unsigned stall_m  = 0;
    bit          hold     = 1'b0;
    logic [15:0] held     = '0;
    int          xfer_cnt = 0;

    always #5 clk = ~clk;

    pe_injector dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_sw_valid  (o_sw_valid),
        .o_sw_data   (o_sw_data),
        .i_sw_ready  (i_sw_ready),
        .o_busy      (o_busy),
        .o_stall_cnt (o_stall_cnt)
    );

    pe_injector #(.DEST_COUNT(4), .DEST_Y0(0)) dut4 (
        .clk         (clk),
        .rstn        (rstn),
        .i_valid     (v4),
        .i_data      (d4),
        .o_ready     (o_ready4),
        .o_sw_valid  (o_valid4),
        .o_sw_data   (o_data4),
        .i_sw_ready  (r4),
        .o_busy      (o_busy4),
        .o_stall_cnt (o_stall4)
    );

    // Expected packet from the field layout: payload, src X, src Y, dst X, dst Y.
    function automatic logic [15:0] pkt(input logic [7:0] d, input int y);
        return 16'(int'(d) * 256 + SX * 64 + SY * 16 + DX * 4 + y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        i_valid = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    // Monitor: check state left by the last edge, then predict the next edge.
    always @(negedge clk) begin
        if (hold) begin
            check("hold_valid", 32'(o_sw_valid), 32'd1);
            check("hold_data", 32'(o_sw_data), 32'(held));
        end
        check("stall_cnt", 32'(o_stall_cnt), stall_m);
        check("busy", 32'(o_busy), 32'(exp_q.size() != 0));
        check("ready", 32'(o_ready), 32'(((exp_q.size() + DC - 1) / DC) < DEPTH));
        hold = 1'b0;
        if (!rstn) begin
            exp_q.delete();
            stall_m = 0;
        end else begin
            if (o_sw_valid && i_sw_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pkt: got 0x%0h expected none", o_sw_data);
                end else begin
                    check("pkt", 32'(o_sw_data), 32'(exp_q.pop_front()));
                    xfer_cnt++;
                end
            end
            if (o_sw_valid && !i_sw_ready) begin
                hold = 1'b1;
                held = o_sw_data;
                if (stall_m < 32'hFFFF) stall_m++;
            end
            if (i_valid && o_ready) begin
                for (int k = 0; k < DC; k++) exp_q.push_back(pkt(i_data, DY0 + k));
            end
        end
    end

    initial begin
        int base;
        int cnt;
        int rises;
        bit prev;
        bit done;

        rstn = 1'b0; i_valid = 1'b0; i_data = '0; i_sw_ready = 1'b0;
        v4 = 1'b0; d4 = '0; r4 = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        check("rst_valid", 32'(o_sw_valid), 32'd0);
        check("rst_data", 32'(o_sw_data), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_stall", 32'(o_stall_cnt), 32'd0);

        // Single word, no backpressure
        i_sw_ready = 1'b1;
        i_valid = 1'b1; i_data = 8'hA5;
        tick();
        i_valid = 1'b0;
        check("single_nobypass", 32'(o_sw_valid), 32'd0);
        tick();
        check("single_lat_valid", 32'(o_sw_valid), 32'd1);
        check("single_p0", 32'(o_sw_data), 32'hA504);
        tick();
        check("single_p1", 32'(o_sw_data), 32'hA505);
        tick();
        check("single_end_valid", 32'(o_sw_valid), 32'd0);
        check("single_end_busy", 32'(o_busy), 32'd0);

        // Backpressure
        do_reset();
        i_sw_ready = 1'b0;
        i_valid = 1'b1; i_data = 8'h3C;
        tick();
        i_valid = 1'b0;
        tick();
        check("bp_valid", 32'(o_sw_valid), 32'd1);
        repeat (5) tick();
        check("bp_stall5", 32'(o_stall_cnt), 32'd5);
        check("bp_held", 32'(o_sw_data), 32'h3C04);
        i_sw_ready = 1'b1;
        tick();
        check("bp_p1", 32'(o_sw_data), 32'h3C05);
        tick();
        check("bp_end", 32'(o_sw_valid), 32'd0);

        // Fill the FIFO while stalled
        do_reset();
        i_sw_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1; i_data = 8'(8'h10 + k);
            tick();
            if (k == 2) check("fill_ready3", 32'(o_ready), 32'd1);
            if (k == 3) check("fill_ready4", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        base = xfer_cnt;
        i_sw_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            tick();
            if (exp_q.size() == 0 && !o_busy) done = 1'b1;
        end
        check("fill_drained", 32'(done), 32'd1);
        check("fill_count", 32'(xfer_cnt - base), 32'd8);

        // Back-to-back words with no bubble
        do_reset();
        i_sw_ready = 1'b1;
        cnt = 0; rises = 0; prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            i_valid = (c < 3);
            i_data  = 8'(c + 1);
            tick();
            if (o_sw_valid) cnt++;
            if (o_sw_valid && !prev) rises++;
            prev = o_sw_valid;
        end
        i_valid = 1'b0;
        check("b2b_cycles", 32'(cnt), 32'd6);
        check("b2b_one_burst", 32'(rises), 32'd1);

        // Reset in the middle of a fan-out
        do_reset();
        i_sw_ready = 1'b1;
        i_valid = 1'b1; i_data = 8'hA5;
        tick();
        i_valid = 1'b0;
        tick();
        check("rm_p0", 32'(o_sw_data), 32'hA504);
        tick();
        rstn = 1'b0;
        tick();
        check("rm_valid", 32'(o_sw_valid), 32'd0);
        check("rm_ready", 32'(o_ready), 32'd1);
        check("rm_stall", 32'(o_stall_cnt), 32'd0);
        rstn = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_sw_valid) cnt++;
        end
        check("rm_no_residue", 32'(cnt), 32'd0);

        // Four-way fan-out instance
        v4 = 1'b1; d4 = 8'h77;
        tick();
        v4 = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("dc4_valid", 32'(o_valid4), 32'd1);
            check("dc4_pkt", 32'(o_data4), 32'(16'h7704 + 16'(k)));
            tick();
        end
        check("dc4_end_valid", 32'(o_valid4), 32'd0);
        check("dc4_end_busy", 32'(o_busy4), 32'd0);
        check("dc4_stall", 32'(o_stall4), 32'd0);
        check("dc4_ready", 32'(o_ready4), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_valid    = 1'($urandom_range(0, 1));
            i_data     = 8'($urandom);
            i_sw_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_valid = 1'b0;
        i_sw_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (exp_q.size() == 0 && !o_busy) done = 1'b1;
        end
        check("rand_drained", 32'(done), 32'd1);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
